// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU:
// oper codes, ALU_op field positions and FSM states.
package alu_pkg;

  localparam logic [3:0] OP_SLL = 4'd0;
  localparam logic [3:0] OP_SRL = 4'd1;
  localparam logic [3:0] OP_ROL = 4'd2;
  localparam logic [3:0] OP_ROR = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_BTR = 4'd8;
  localparam logic [3:0] OP_SEQ = 4'd9;
  localparam logic [3:0] OP_SLT = 4'd10;
  localparam logic [3:0] OP_SLE = 4'd11;
  localparam logic [3:0] OP_SCO = 4'd12;

  localparam int CIN_BIT  = 7;
  localparam int OPER_HI  = 6;
  localparam int OPER_LO  = 3;
  localparam int INVA_BIT = 2;
  localparam int INVB_BIT = 1;
  localparam int SGN_BIT  = 0;

  localparam logic [7:0] ALU_OP_IDLE = 8'h01;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

endpackage

// File: rtl/alu_shift_step.sv
// One-bit shift/rotate step used by the
// iterative shift datapath.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = din;
    unique case (sel)
      OP_SLL[1:0]: dout = {din[WIDTH-2:0], 1'b0};
      OP_SRL[1:0]: dout = {1'b0, din[WIDTH-1:1]};
      OP_ROL[1:0]: dout = {din[WIDTH-2:0], din[WIDTH-1]};
      OP_ROR[1:0]: dout = {din[0], din[WIDTH-1:1]};
      default:     dout = din;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle execute-stage ALU: single-cycle
// arithmetic/logic, iterative one-bit-per-cycle shifts.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       ALU_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             ofl,
  output logic             zero,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             ofl_q, ofl_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic [3:0]       oper;
  logic             cin, sgn;
  logic [WIDTH-1:0] a_p, b_p;
  logic [SHW-1:0]   cnt_in;
  logic             is_idle, is_shift;
  logic [WIDTH-1:0] sum, sum_nc, res;
  logic             of, er, carry;
  logic [WIDTH-1:0] step_out;

  assign oper   = ALU_op[OPER_HI:OPER_LO];
  assign cin    = ALU_op[CIN_BIT];
  assign sgn    = ALU_op[SGN_BIT];
  assign a_p    = ALU_op[INVA_BIT] ? ~A : A;
  assign b_p    = ALU_op[INVB_BIT] ? ~B : B;
  assign cnt_in = B[SHW-1:0];

  // oper 0 with signed=1 is the idle word, not SLL
  assign is_idle  = (oper == OP_SLL) && sgn;
  assign is_shift = (oper <= OP_ROR) && !is_idle;

  assign sum    = a_p + b_p + {{(WIDTH-1){1'b0}}, cin};
  assign sum_nc = a_p + b_p;
  assign carry  = sum_nc < a_p;

  always_comb begin
    res = '0;
    of  = 1'b0;
    er  = 1'b0;
    unique case (oper)
      OP_SLL, OP_SRL, OP_ROL, OP_ROR:
        res = is_idle ? '0 : a_p;
      OP_ADD: begin
        res = sum;
        of  = sgn && (a_p[WIDTH-1] == b_p[WIDTH-1])
                  && (sum[WIDTH-1] != a_p[WIDTH-1]);
      end
      OP_AND: res = a_p & b_p;
      OP_OR:  res = a_p | b_p;
      OP_XOR: res = a_p ^ b_p;
      OP_BTR: begin
        for (int i = 0; i < WIDTH; i++)
          res[i] = a_p[WIDTH-1-i];
      end
      OP_SEQ: res[0] = (a_p == b_p);
      OP_SLT: res[0] = ($signed(a_p) < $signed(b_p));
      OP_SLE: res[0] = ($signed(a_p) <= $signed(b_p));
      OP_SCO: begin
        res[0] = carry;
        of     = carry;
      end
      default: er = 1'b1;
    endcase
  end

  alu_shift_step #(.WIDTH(WIDTH)) u_step (
    .sel  (sel_q),
    .din  (sr_q),
    .dout (step_out)
  );

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    result_d = result_q;
    done_d   = 1'b0;
    ofl_d    = ofl_q;
    zero_d   = zero_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_shift && (cnt_in != '0)) begin
            sr_d    = a_p;
            cnt_d   = cnt_in;
            sel_d   = oper[1:0];
            state_d = S_SHIFT;
          end else begin
            result_d = res;
            ofl_d    = of;
            err_d    = er;
            zero_d   = (res == '0);
            done_d   = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        sr_d  = step_out;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == SHW'(1)) begin
          result_d = step_out;
          ofl_d    = 1'b0;
          err_d    = 1'b0;
          zero_d   = (step_out == '0);
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      sel_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      ofl_q    <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      result_q <= result_d;
      done_q   <= done_d;
      ofl_q    <= ofl_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = (state_q == S_SHIFT);
  assign ofl    = ofl_q;
  assign zero   = zero_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed cases
// plus random ops against an arithmetic reference.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  ALU_op = 8'h00;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [15:0] result;
  logic        done, busy, ofl, zero, err;

  int n_chk  = 0;
  int n_pass = 0;

  alu_exec #(.WIDTH(16), .SHW(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ALU_op (ALU_op),
    .A      (A),
    .B      (B),
    .result (result),
    .done   (done),
    .busy   (busy),
    .ofl    (ofl),
    .zero   (zero),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic ref_op(input  logic [7:0]  op,
                        input  logic [15:0] a,
                        input  logic [15:0] b,
                        output logic [15:0] r,
                        output logic        o,
                        output logic        e,
                        output int          lat);
    logic [15:0] ap, bp;
    int n, s;
    ap  = op[2] ? ~a : a;
    bp  = op[1] ? ~b : b;
    n   = int'(b[3:0]);
    r   = '0;
    o   = 1'b0;
    e   = 1'b0;
    lat = 1;
    case (op[6:3])
      4'd0: if (!op[0]) begin r = ap << n; lat = 1 + n; end
      4'd1: begin r = ap >> n; lat = 1 + n; end
      4'd2: begin
        r = (n == 0) ? ap : ((ap << n) | (ap >> (16 - n)));
        lat = 1 + n;
      end
      4'd3: begin
        r = (n == 0) ? ap : ((ap >> n) | (ap << (16 - n)));
        lat = 1 + n;
      end
      4'd4: begin
        s = int'($signed(ap)) + int'($signed(bp)) + int'(op[7]);
        r = ap + bp + {15'b0, op[7]};
        o = op[0] && (s > 32767 || s < -32768);
      end
      4'd5: r = ap & bp;
      4'd6: r = ap | bp;
      4'd7: r = ap ^ bp;
      4'd8: for (int i = 0; i < 16; i++) r[i] = ap[15-i];
      4'd9:  r = (ap == bp) ? 16'd1 : 16'd0;
      4'd10: r = ($signed(ap) <  $signed(bp)) ? 16'd1 : 16'd0;
      4'd11: r = ($signed(ap) <= $signed(bp)) ? 16'd1 : 16'd0;
      4'd12: begin
        s = int'(ap) + int'(bp);
        o = (s > 65535);
        r = {15'b0, o};
      end
      default: e = 1'b1;
    endcase
  endtask

  task automatic run_op(input logic [7:0]  op,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        input bit          poke);
    logic [15:0] er;
    logic eo, ee;
    int lat, cyc, bcnt;
    ref_op(op, a, b, er, eo, ee, lat);
    @(negedge clk);
    start = 1'b1; ALU_op = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
    cyc  = 1;
    bcnt = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      if (poke && cyc == 2) begin
        start = 1'b1; ALU_op = 8'h21;
        A = 16'($urandom); B = 16'($urandom);
      end
      if (poke && cyc == 3) start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", cyc, lat);
    chk("busy_cycles", bcnt, lat - 1);
    chk("busy_at_done", {31'b0, busy}, 0);
    chk("result", {16'b0, result}, {16'b0, er});
    chk("ofl", {31'b0, ofl}, {31'b0, eo});
    chk("err", {31'b0, err}, {31'b0, ee});
    chk("zero", {31'b0, zero}, {31'b0, (er == 16'h0)});
    @(posedge clk); #1;
    chk("done_single", {31'b0, done}, 0);
  endtask

  initial begin
    logic [15:0] er;
    logic eo, ee;
    int lat, dcnt;
    logic [7:0]  bop [3];
    logic [15:0] ba  [3];
    logic [15:0] bb  [3];
    logic [15:0] bex [3];

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_result", {16'b0, result}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_ofl", {31'b0, ofl}, 0);
    chk("rst_zero", {31'b0, zero}, 0);
    chk("rst_err", {31'b0, err}, 0);

    run_op(8'h21, 16'h7FFF, 16'h0001, 1'b0);
    chk("add_ovf_result", {16'b0, result}, 32'h8000);
    run_op(8'hA5, 16'h0005, 16'h0003, 1'b0);
    chk("sub_result", {16'b0, result}, 32'hFFFE);
    run_op(8'h60, 16'hFFFF, 16'h0001, 1'b0);
    chk("sco_ofl", {31'b0, ofl}, 1);
    run_op(8'h18, 16'h0001, 16'h0004, 1'b1);
    chk("ror_result", {16'b0, result}, 32'h1000);
    run_op(8'h00, 16'hABCD, 16'h0010, 1'b0);
    chk("sll0_result", {16'b0, result}, 32'hABCD);
    run_op(8'h01, 16'h1234, 16'h0005, 1'b0);
    chk("idle_result", {16'b0, result}, 0);

    bop[0] = 8'h40; ba[0] = 16'h0001; bb[0] = 16'h0000; bex[0] = 16'h8000;
    bop[1] = 8'h51; ba[1] = 16'hFFFF; bb[1] = 16'h0001; bex[1] = 16'h0001;
    bop[2] = 8'h59; ba[2] = 16'h0003; bb[2] = 16'h0003; bex[2] = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b1; ALU_op = bop[i]; A = ba[i]; B = bb[i];
      @(posedge clk); #1;
      chk("b2b_done", {31'b0, done}, 1);
      chk("b2b_result", {16'b0, result}, {16'b0, bex[i]});
    end
    @(negedge clk);
    start = 1'b0;
    run_op(8'h68, 16'h1234, 16'h5678, 1'b0);
    chk("illegal_err", {31'b0, err}, 1);

    @(negedge clk);
    start = 1'b1; ALU_op = 8'h08; A = 16'hFFFF; B = 16'h000F;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_result", {16'b0, result}, 0);
    chk("abort_done", {31'b0, done}, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_ofl", {31'b0, ofl}, 0);
    chk("abort_zero", {31'b0, zero}, 0);
    chk("abort_err", {31'b0, err}, 0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    run_op(8'h20, 16'h1111, 16'h2222, 1'b0);

    for (int i = 0; i < 150; i++)
      run_op(8'($urandom), 16'($urandom), 16'($urandom), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
# alu_exec

Multi-cycle 16-bit execution unit in the execute stage. It consumes the 8-bit `ALU_op` control word produced by the ALU control decoder and performs the encoded operation on two register operands. Single-cycle operations finish in one cycle. Shifts and rotates run iteratively, one bit per cycle. A start/done handshake lets the pipeline control logic stall while the unit is busy.

## Interface
- `WIDTH`, 16, operand/result width (design verified at 16 only)
- `SHW`, 4, shift-amount width, log2(WIDTH)

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request; accepted when `busy`=0
- `ALU_op`  in  8  control word: [7] Cin, [6:3] oper, [2] invA, [1] invB, [0] signed
- `A`  in  WIDTH  operand A (Rs)
- `B`  in  WIDTH  operand B (Rt or immediate); B[SHW-1:0] is the shift amount
- `result`  out  WIDTH  registered result; holds until the next completion
- `done`  out  1  one-cycle pulse: `result`/flags valid
- `busy`  out  1  iterative op in flight
- `ofl`  out  1  signed overflow (oper 4, signed=1) or carry-out (oper 12); 0 otherwise
- `zero`  out  1  registered, set when `result`==0 at completion
- `err`  out  1  registered, set at completion of an illegal oper (13–15)

## Operation
- Operands are latched on accept: A' = invA ? ~A : A; B' = invB ? ~B : B.
- oper 0 SLL, 1 SRL (logical, zero fill), 2 ROL, 3 ROR: iterative on A', count = B[3:0].
- oper 4 ADD: A'+B'+Cin, WIDTH-bit wrap. SUB arrives as invA=1, Cin=1, giving B−A.
  - `ofl` = (A'[15]==B'[15]) && (sum[15]!=A'[15]) when signed=1; 0 when signed=0.
- oper 5 AND: A'&B'. ANDN arrives as invB=1.
- oper 6 OR: A'|B'. Used by SLBI; the upstream operand mux pre-shifts A.
- oper 7 XOR: A'^B'.
- oper 8 BTR: result[i] = A'[15−i].
- oper 9 SEQ, 10 SLT (signed), 11 SLE (signed): result = {15'b0, cond}.
- oper 12 SCO: result = {15'b0, carry-out of A+B (unsigned)}; `ofl` = the same carry.
- opers 13–15: result 0, `err`=1, single-cycle.
- Idle word 8'h01 (oper 0, signed=1): result 0, no shift, single-cycle. It must not be confused with SLL, which has signed=0.
- FSM states:
  - IDLE: accept `start`.
    - Single-cycle ops and shifts with count 0: register result/flags and pulse `done`; stay in IDLE.
    - Shifts with count>0: load shift register = A', counter = count; go to SHIFT, `busy`=1.
  - SHIFT: each cycle shift/rotate by 1 and decrement the counter.
    - On the cycle the counter reaches 0: write `result`, pulse `done`, drop `busy`, return to IDLE.
- `start` while `busy`=1 is ignored with no effect; the source must hold it.
- `ofl`, `err` and `zero` are updated only at completion; they are stale otherwise.

## Timing
- Reset values: `result`=0, `done`=0, `busy`=0, `ofl`=0, `zero`=0, `err`=0; FSM in IDLE; counter 0.
- Latency, counted from the cycle `start` is accepted:
  - 1 cycle for non-shift ops and for shift count 0.
  - 1+n cycles for a shift/rotate by n>0 (max 16).
- `busy` is high from the cycle after accept up to, but not including, the `done` cycle.
- A new `start` in the `done` cycle is accepted, so there are no bubbles.
- Single-cycle ops sustain one op per cycle, with `done` high every cycle.
- `done` is never high for two consecutive cycles belonging to the same op.
- `rst` mid-SHIFT aborts immediately: IDLE, all outputs return to reset values, and no `done` pulse is produced.
- Shift count uses B[3:0] only. Shift by 0 returns A' unchanged in 1 cycle. Rotate by 16 is impossible, because the count is 4 bits.

## Structure
- Package `alu_pkg`:
  - oper code constants (OP_SLL … OP_SCO).
  - `ALU_op` field positions.
  - `ALU_OP_IDLE` = 8'h01.
  - FSM state typedef.
- Sub-module `alu_shift_step`: combinational one-bit SLL/SRL/ROL/ROR on a WIDTH vector, selected by oper[1:0]. It is instantiated once in the SHIFT datapath.

## Test plan
- Reset, then ADD 0x7FFF+0x0001 with op 8'h21 → `done` next cycle, result 0x8000, `ofl`=1, `zero`=0.
- SUB with op 8'hA5, A=0x0005, B=0x0003 → result 0xFFFE, `ofl`=0. Then SCO with op 8'h60, A=0xFFFF, B=0x0001 → result 0x0001, `ofl`=1.
- ROR with op 8'h18, A=0x0001, B=0x0004 → `busy` for 4 cycles, `done` in cycle 5, result 0x1000. A second `start` issued while busy is ignored.
- SLL with op 8'h00 and B[3:0]=0 → single-cycle, result=A. Idle op 8'h01 with A=0x1234 → result 0.
- Back-to-back BTR A=0x0001 → 0x8000, SLT A=0xFFFF, B=0x0001 → 0x0001, SLE A=B=0x0003 → 0x0001, and `done` stays high three cycles straight. Then oper 13 → `err`=1, result 0.
- Assert `rst` two cycles into an SRL by 15 → outputs return to reset values, no `done` pulse. The next ADD is accepted normally.
